// File: rtl/string_hw_pkg.sv
// rtl/string_hw_pkg.sv - shared types, register map and helpers for the String_HW front end
// Contents: string geometry (MAX_BLOCKS, STR_BYTES), str_t, ctrl_state_t,
// register word offsets, core op codes and word pack/unpack helpers.
package string_hw_pkg;

    localparam int MAX_BLOCKS = 2;
    localparam int STR_BYTES  = MAX_BLOCKS * 4;
    localparam int IDX_W      = $clog2(STR_BYTES);

    // Byte 0 of the string sits in the most significant byte of the packed vector.
    typedef logic [0:STR_BYTES-1][7:0] str_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } ctrl_state_t;

    localparam int REG_CTRL   = 0;
    localparam int REG_STATUS = 1;
    localparam int REG_A_BASE = 2;
    localparam int REG_B_BASE = 2 + MAX_BLOCKS;
    localparam int REG_R_BASE = 2 + 2 * MAX_BLOCKS;

    localparam logic [3:0] OP_CMP   = 4'd0;
    localparam logic [3:0] OP_UPPER = 4'd1;
    localparam logic [3:0] OP_LOWER = 4'd2;

    // Bus word k carries string bytes 4k..4k+3 with the lowest string byte in
    // bits [7:0], so a little-endian memcpy of a C string lands in order.
    function automatic logic [31:0] str_get_word(input str_t s, input int k);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            w[8*j +: 8] = s[IDX_W'(4*k + j)];
        end
        return w;
    endfunction

    function automatic str_t str_put_word(input str_t s, input int k, input logic [31:0] w);
        str_t r;
        r = s;
        for (int j = 0; j < 4; j++) begin
            r[IDX_W'(4*k + j)] = w[8*j +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/string_hw_avalon_ctrl_if.sv
// rtl/string_hw_avalon_ctrl_if.sv - Avalon-MM slave bus bundle for the String_HW front end
// Signals: address (word), chipselect, write, writedata, read, readdata.
// Modports: master (bus side, e.g. NIOS2 interconnect), slave (this block).
interface string_hw_avalon_ctrl_if #(
    parameter int ADDR_W = 4
);

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write;
    logic [31:0]       writedata;
    logic              read;
    logic [31:0]       readdata;

    modport master (
        output address, chipselect, write, writedata, read,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write, writedata, read,
        output readdata
    );

endinterface

// File: rtl/string_hw_regfile.sv
// rtl/string_hw_regfile.sv - address decode, byte packing and read mux for the String_HW front end
// Ports: clk, reset_n (async, active low); bus (Avalon slave modport);
// busy (blocks A/B writes); status_word (STATUS readback); result_load/result_in
// (capture from core); ctrl_* (decoded CTRL write fields); a_out/b_out (operands).
module string_hw_regfile
    import string_hw_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    string_hw_avalon_ctrl_if.slave bus,
    input  logic       busy,
    input  logic [31:0] status_word,
    input  logic       result_load,
    input  str_t       result_in,
    output logic       ctrl_start,
    output logic       ctrl_clear,
    output logic       ctrl_irq_en,
    output logic [3:0] ctrl_index,
    output logic       ctrl_wr,
    output str_t       a_out,
    output str_t       b_out
);

    str_t        a_q, a_d;
    str_t        b_q, b_d;
    str_t        r_q, r_d;
    logic [31:0] readdata_q, readdata_d;

    logic wr_en;
    logic rd_en;

    assign wr_en = bus.chipselect & bus.write;
    assign rd_en = bus.chipselect & bus.read;

    assign ctrl_wr     = wr_en && (bus.address == ADDR_W'(REG_CTRL));
    assign ctrl_start  = bus.writedata[0];
    assign ctrl_clear  = bus.writedata[1];
    assign ctrl_irq_en = bus.writedata[2];
    assign ctrl_index  = bus.writedata[7:4];

    assign a_out        = a_q;
    assign b_out        = b_q;
    assign bus.readdata = readdata_q;

    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        r_d        = r_q;
        readdata_d = readdata_q;

        // Operands are frozen while the core may be sampling them.
        if (wr_en && !busy) begin
            for (int k = 0; k < MAX_BLOCKS; k++) begin
                if (bus.address == ADDR_W'(REG_A_BASE + k)) begin
                    a_d = str_put_word(a_q, k, bus.writedata);
                end
                if (bus.address == ADDR_W'(REG_B_BASE + k)) begin
                    b_d = str_put_word(b_q, k, bus.writedata);
                end
            end
        end

        if (result_load) begin
            r_d = result_in;
        end

        if (rd_en) begin
            readdata_d = '0;
            if (bus.address == ADDR_W'(REG_STATUS)) begin
                readdata_d = status_word;
            end
            for (int k = 0; k < MAX_BLOCKS; k++) begin
                if (bus.address == ADDR_W'(REG_A_BASE + k)) readdata_d = str_get_word(a_q, k);
                if (bus.address == ADDR_W'(REG_B_BASE + k)) readdata_d = str_get_word(b_q, k);
                if (bus.address == ADDR_W'(REG_R_BASE + k)) readdata_d = str_get_word(r_q, k);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            readdata_q <= '0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            r_q        <= r_d;
            readdata_q <= readdata_d;
        end
    end

endmodule

// File: rtl/string_hw_avalon_ctrl.sv
// rtl/string_hw_avalon_ctrl.sv - Avalon-MM front end that launches the String_HW core
// Ports: clk, reset_n (async, active low); avs (Avalon-MM slave modport);
// core_go/core_index/core_A/core_B to the core; core_done/core_result from it;
// irq (only when STRING_HW_IRQ_EN is defined).
// Optional feature macro: STRING_HW_IRQ_EN (interrupt output + CTRL bit2 IRQ_ENABLE).
module string_hw_avalon_ctrl
    import string_hw_pkg::*;
#(
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    string_hw_avalon_ctrl_if.slave avs,
    output logic       core_go,
    output logic [3:0] core_index,
    output str_t       core_A,
    output str_t       core_B,
    input  logic       core_done,
    input  str_t       core_result
`ifdef STRING_HW_IRQ_EN
    ,
    output logic       irq
`endif
);

    localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);

    ctrl_state_t state_q, state_d;
    logic [3:0]  index_q, index_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic [31:0] cnt_q, cnt_d;

    logic        busy;
    logic        result_load;
    logic        irq_en_bit;
    logic [31:0] status_word;

    logic        ctrl_wr;
    logic        ctrl_start;
    logic        ctrl_clear;
    logic        ctrl_irq_en;
    logic [3:0]  ctrl_index;

    logic        start_acc;
    logic        clear_acc;

    string_hw_regfile #(
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (avs),
        .busy        (busy),
        .status_word (status_word),
        .result_load (result_load),
        .result_in   (core_result),
        .ctrl_start  (ctrl_start),
        .ctrl_clear  (ctrl_clear),
        .ctrl_irq_en (ctrl_irq_en),
        .ctrl_index  (ctrl_index),
        .ctrl_wr     (ctrl_wr),
        .a_out       (core_A),
        .b_out       (core_B)
    );

    // core_go comes straight from the state flop so reset drops it without a clock.
    assign busy        = (state_q != IDLE);
    assign core_go     = (state_q == BUSY);
    assign core_index  = index_q;
    assign status_word = {24'h0, index_q, irq_en_bit, timeout_q, done_q, busy};

    // CTRL commands only take effect in IDLE; START wins over CLEAR.
    assign start_acc = ctrl_wr && ctrl_start && (state_q == IDLE);
    assign clear_acc = ctrl_wr && ctrl_clear && (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        cnt_d       = cnt_q;
        result_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d   = BUSY;
                    index_d   = ctrl_index;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                end else if (clear_acc) begin
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 32'd1;
                // Completion takes priority over a timeout expiring on the same edge.
                if (core_done) begin
                    result_load = 1'b1;
                    done_d      = 1'b1;
                    state_d     = RELEASE;
                end else if ((TMO != 32'd0) && (cnt_d == TMO)) begin
                    timeout_d = 1'b1;
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            index_q   <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef STRING_HW_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        irq_d    = irq_en_q & (done_q | timeout_q);
        if (ctrl_wr && (state_q == IDLE)) begin
            irq_en_d = ctrl_irq_en;
        end
        if (start_acc || clear_acc) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq        = irq_q;
    assign irq_en_bit = irq_en_q;
`else
    logic unused_ctrl_irq_en;

    assign unused_ctrl_irq_en = ctrl_irq_en;
    assign irq_en_bit         = 1'b0;
`endif

endmodule

// File: tb/tb_string_hw_avalon_ctrl.sv
// tb/tb_string_hw_avalon_ctrl.sv - randomized self-checking bench for string_hw_avalon_ctrl
module tb_string_hw_avalon_ctrl;
    import string_hw_pkg::*;

    localparam int ADDR_W = 4;
    localparam int TMO    = 16;
    localparam int NREGS  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    string_hw_avalon_ctrl_if #(.ADDR_W(ADDR_W)) avs ();

    logic       core_go;
    logic [3:0] core_index;
    str_t       core_A;
    str_t       core_B;
    logic       core_done;
    str_t       core_result;
`ifdef STRING_HW_IRQ_EN
    logic       irq;
`endif

    string_hw_avalon_ctrl #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .avs         (avs),
        .core_go     (core_go),
        .core_index  (core_index),
        .core_A      (core_A),
        .core_B      (core_B),
        .core_done   (core_done),
        .core_result (core_result)
`ifdef STRING_HW_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    int checks = 0;
    int errors = 0;

    byte unsigned m_a[STR_BYTES];
    byte unsigned m_b[STR_BYTES];
    byte unsigned m_r[STR_BYTES];
    bit           m_done;
    bit           m_to;
    bit           m_irqen;
    logic [3:0]   m_idx;

    function automatic void model_reset();
        for (int i = 0; i < STR_BYTES; i++) begin
            m_a[i] = 0; m_b[i] = 0; m_r[i] = 0;
        end
        m_done = 0; m_to = 0; m_irqen = 0; m_idx = 0;
    endfunction

    function automatic logic [31:0] pack_word(input byte unsigned s[STR_BYTES], input int k);
        return {s[4*k+3], s[4*k+2], s[4*k+1], s[4*k]};
    endfunction

    // String byte i occupies the i-th most significant byte of the core vector.
    function automatic logic [8*STR_BYTES-1:0] to_vec(input byte unsigned s[STR_BYTES]);
        logic [8*STR_BYTES-1:0] v;
        for (int i = 0; i < STR_BYTES; i++) v[8*(STR_BYTES-1-i) +: 8] = s[i];
        return v;
    endfunction

    function automatic logic [31:0] exp_status(input bit busy);
        bit ie;
        ie = 1'b0;
`ifdef STRING_HW_IRQ_EN
        ie = m_irqen;
`endif
        return {24'h0, m_idx, ie, m_to, m_done, busy};
    endfunction

    function automatic logic [31:0] exp_reg(input int addr, input bit busy);
        if (addr == 1) return exp_status(busy);
        if (addr >= 2 && addr < 2 + MAX_BLOCKS) return pack_word(m_a, addr - 2);
        if (addr >= 2 + MAX_BLOCKS && addr < 2 + 2*MAX_BLOCKS) return pack_word(m_b, addr - 2 - MAX_BLOCKS);
        if (addr >= 2 + 2*MAX_BLOCKS && addr < 2 + 3*MAX_BLOCKS) return pack_word(m_r, addr - 2 - 2*MAX_BLOCKS);
        return 32'h0;
    endfunction

    // Behaviour of the String_HW core as seen by software.
    function automatic void core_model(input logic [3:0] idx, output byte unsigned r[STR_BYTES]);
        bit eq;
        eq = 1'b1;
        for (int i = 0; i < STR_BYTES; i++) begin
            if (m_a[i] != m_b[i]) eq = 1'b0;
            case (idx)
                4'd1:    r[i] = (m_a[i] >= 8'h61 && m_a[i] <= 8'h7a) ? 8'(m_a[i] - 8'h20) : m_a[i];
                4'd2:    r[i] = (m_a[i] >= 8'h41 && m_a[i] <= 8'h5a) ? 8'(m_a[i] + 8'h20) : m_a[i];
                default: r[i] = 8'h00;
            endcase
        end
        if (idx == 4'd0) r[STR_BYTES-1] = {7'b0, eq};
    endfunction

    function automatic void randomize_operands();
        for (int i = 0; i < STR_BYTES; i++) begin
            m_a[i] = 8'($urandom_range(32'h40, 32'h7e));
            m_b[i] = 8'($urandom_range(32'h40, 32'h7e));
        end
    endfunction

    // All bus/core tasks are entered and left on a falling clock edge.
    task automatic bus_write(input int addr, input logic [31:0] data);
        avs.address    = ADDR_W'(addr);
        avs.writedata  = data;
        avs.chipselect = 1'b1;
        avs.write      = 1'b1;
        @(negedge clk);
        avs.chipselect = 1'b0;
        avs.write      = 1'b0;
    endtask

    task automatic bus_read(input int addr, output logic [31:0] data);
        avs.address    = ADDR_W'(addr);
        avs.chipselect = 1'b1;
        avs.read       = 1'b1;
        @(negedge clk);
        avs.chipselect = 1'b0;
        avs.read       = 1'b0;
        data           = avs.readdata;
    endtask

    task automatic write_operands();
        for (int k = 0; k < MAX_BLOCKS; k++) bus_write(REG_A_BASE + k, pack_word(m_a, k));
        for (int k = 0; k < MAX_BLOCKS; k++) bus_write(REG_B_BASE + k, pack_word(m_b, k));
    endtask

    task automatic launch(input logic [3:0] idx, input bit ie);
        bus_write(REG_CTRL, {24'h0, idx, 1'b0, ie, 2'b01});
        m_idx = idx; m_done = 1'b0; m_to = 1'b0; m_irqen = ie;
    endtask

    task automatic core_finish(input byte unsigned res[STR_BYTES]);
        core_result = to_vec(res);
        core_done   = 1'b1;
        @(negedge clk);
        core_done   = 1'b0;
        m_r    = res;
        m_done = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        #12;
        checks++; if (core_go !== 1'b0) begin errors++; $display("FAIL reset_core_go got %b exp 0", core_go); end
        checks++; if (core_index !== 4'd0) begin errors++; $display("FAIL reset_core_index got %h exp 0", core_index); end
        checks++; if (core_A !== '0 || core_B !== '0) begin errors++; $display("FAIL reset_operands got %h/%h exp 0", core_A, core_B); end
        checks++; if (avs.readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h exp 0", avs.readdata); end
`ifdef STRING_HW_IRQ_EN
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        model_reset();
        for (int a = 0; a < NREGS; a++) begin
            bus_read(a, rd);
            checks++; if (rd !== exp_reg(a, 1'b0)) begin errors++; $display("FAIL reset_reg[%0d] got %h exp %h", a, rd, exp_reg(a, 1'b0)); end
        end
    endtask

    task automatic test_transform(input int iters);
        logic [31:0] rd;
        byte unsigned res[STR_BYTES];
        logic [3:0] idx;
        for (int it = 0; it < iters; it++) begin
            randomize_operands();
            if (it == 0) begin
                for (int i = 0; i < STR_BYTES; i++) m_a[i] = 8'(8'h61 + i);
                idx = OP_UPPER;
            end else begin
                idx = ($urandom_range(0, 1) == 0) ? OP_UPPER : OP_LOWER;
            end
            write_operands();
            checks++; if (core_go !== 1'b0) begin errors++; $display("FAIL xf_go_idle got %b exp 0", core_go); end
            launch(idx, 1'b0);
            checks++; if (core_go !== 1'b1) begin errors++; $display("FAIL xf_go_rise got %b exp 1", core_go); end
            checks++; if (core_index !== idx) begin errors++; $display("FAIL xf_index got %h exp %h", core_index, idx); end
            checks++; if (core_A !== to_vec(m_a)) begin errors++; $display("FAIL xf_core_A got %h exp %h", core_A, to_vec(m_a)); end
            checks++; if (core_B !== to_vec(m_b)) begin errors++; $display("FAIL xf_core_B got %h exp %h", core_B, to_vec(m_b)); end
            repeat ($urandom_range(0, 6)) @(negedge clk);
            checks++; if (core_go !== 1'b1) begin errors++; $display("FAIL xf_go_hold got %b exp 1", core_go); end
            core_model(idx, res);
            core_finish(res);
            checks++; if (core_go !== 1'b0) begin errors++; $display("FAIL xf_go_release got %b exp 0", core_go); end
            bus_read(REG_STATUS, rd);
            checks++; if (rd !== exp_status(1'b1)) begin errors++; $display("FAIL xf_status_release got %h exp %h", rd, exp_status(1'b1)); end
            bus_read(REG_STATUS, rd);
            checks++; if (rd !== exp_status(1'b0)) begin errors++; $display("FAIL xf_status_idle got %h exp %h", rd, exp_status(1'b0)); end
            checks++; if (core_go !== 1'b0) begin errors++; $display("FAIL xf_go_idle_after got %b exp 0", core_go); end
            for (int k = 0; k < MAX_BLOCKS; k++) begin
                bus_read(REG_R_BASE + k, rd);
                checks++; if (rd !== pack_word(m_r, k)) begin errors++; $display("FAIL xf_result[%0d] got %h exp %h", k, rd, pack_word(m_r, k)); end
            end
        end
    endtask

    task automatic test_compare();
        logic [31:0] rd;
        byte unsigned res[STR_BYTES];
        for (int it = 0; it < 3; it++) begin
            randomize_operands();
            if (it == 0) begin
                for (int i = 0; i < STR_BYTES; i++) begin m_a[i] = 0; m_b[i] = 0; end
                m_a[0] = 8'h61; m_a[1] = 8'h62; m_b[0] = 8'h61; m_b[1] = 8'h62;
            end else if (it == 2) begin
                m_b = m_a;
            end
            write_operands();
            launch(OP_CMP, 1'b0);
            checks++; if (core_index !== OP_CMP) begin errors++; $display("FAIL cmp_index got %h exp 0", core_index); end
            repeat ($urandom_range(1, 4)) @(negedge clk);
            core_model(OP_CMP, res);
            core_finish(res);
            @(negedge clk);
            bus_read(REG_STATUS, rd);
            checks++; if (rd !== exp_status(1'b0)) begin errors++; $display("FAIL cmp_status got %h exp %h", rd, exp_status(1'b0)); end
            for (int k = 0; k < MAX_BLOCKS; k++) begin
                bus_read(REG_R_BASE + k, rd);
                checks++; if (rd !== pack_word(m_r, k)) begin errors++; $display("FAIL cmp_result[%0d] got %h exp %h", k, rd, pack_word(m_r, k)); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        byte unsigned res[STR_BYTES];
        randomize_operands();
        write_operands();
        launch(OP_LOWER, 1'b0);
        core_model(OP_LOWER, res);
        core_finish(res);
        bus_write(REG_CTRL, {24'h0, 4'd1, 4'b0001});
        checks++; if (core_go !== 1'b0) begin errors++; $display("FAIL b2b_start_in_release got %b exp 0", core_go); end
        checks++; if (core_index !== OP_LOWER) begin errors++; $display("FAIL b2b_index_kept got %h exp %h", core_index, OP_LOWER); end
        bus_read(REG_STATUS, rd);
        checks++; if (rd !== exp_status(1'b0)) begin errors++; $display("FAIL b2b_status got %h exp %h", rd, exp_status(1'b0)); end
        launch(OP_UPPER, 1'b0);
        checks++; if (core_go !== 1'b1 || core_index !== OP_UPPER) begin errors++; $display("FAIL b2b_relaunch got go=%b idx=%h exp go=1 idx=1", core_go, core_index); end
        repeat (2) @(negedge clk);
        core_model(OP_UPPER, res);
        core_finish(res);
        bus_read(REG_STATUS, rd);
        checks++; if (rd !== exp_status(1'b1)) begin errors++; $display("FAIL b2b_status2 got %h exp %h", rd, exp_status(1'b1)); end
        for (int k = 0; k < MAX_BLOCKS; k++) begin
            bus_read(REG_R_BASE + k, rd);
            checks++; if (rd !== pack_word(m_r, k)) begin errors++; $display("FAIL b2b_result[%0d] got %h exp %h", k, rd, pack_word(m_r, k)); end
        end
    endtask

    task automatic test_busy_writes();
        logic [31:0] rd;
        int go_seen;
        byte unsigned res[STR_BYTES];
        randomize_operands();
        write_operands();
        launch(OP_LOWER, 1'b0);
        bus_write(REG_A_BASE, 32'hFFFF_FFFF);
        bus_write(REG_B_BASE + 1, $urandom);
        bus_write(REG_CTRL, {24'h0, 4'd1, 4'b0011});
        checks++; if (core_A !== to_vec(m_a)) begin errors++; $display("FAIL busy_core_A got %h exp %h", core_A, to_vec(m_a)); end
        checks++; if (core_B !== to_vec(m_b)) begin errors++; $display("FAIL busy_core_B got %h exp %h", core_B, to_vec(m_b)); end
        checks++; if (core_index !== OP_LOWER) begin errors++; $display("FAIL busy_index got %h exp %h", core_index, OP_LOWER); end
        checks++; if (core_go !== 1'b1) begin errors++; $display("FAIL busy_go got %b exp 1", core_go); end
        core_model(OP_LOWER, res);
        core_finish(res);
        go_seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (core_go === 1'b1) go_seen++;
            @(negedge clk);
        end
        checks++; if (go_seen !== 0) begin errors++; $display("FAIL busy_extra_go got %0d exp 0", go_seen); end
        bus_write(REG_STATUS, 32'hFFFF_FFFF);
        bus_write(REG_R_BASE, $urandom);
        bus_write(REG_R_BASE + 3*MAX_BLOCKS, $urandom);
        core_result = $urandom;
        core_done   = 1'b1;
        @(negedge clk);
        core_done   = 1'b0;
        for (int a = 0; a < NREGS; a++) begin
            bus_read(a, rd);
            checks++; if (rd !== exp_reg(a, 1'b0)) begin errors++; $display("FAIL busy_reg[%0d] got %h exp %h", a, rd, exp_reg(a, 1'b0)); end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        int n;
        byte unsigned res[STR_BYTES];
        launch(OP_CMP, 1'b0);
        n = 0;
        while (core_go === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        m_to = 1'b1;
        checks++; if (n !== TMO) begin errors++; $display("FAIL tmo_busy_cycles got %0d exp %0d", n, TMO); end
        bus_read(REG_STATUS, rd);
        checks++; if (rd !== exp_status(1'b1)) begin errors++; $display("FAIL tmo_status got %h exp %h", rd, exp_status(1'b1)); end
        for (int k = 0; k < MAX_BLOCKS; k++) begin
            bus_read(REG_R_BASE + k, rd);
            checks++; if (rd !== pack_word(m_r, k)) begin errors++; $display("FAIL tmo_result[%0d] got %h exp %h", k, rd, pack_word(m_r, k)); end
        end
        bus_write(REG_CTRL, 32'h0000_0002);
        m_done = 1'b0; m_to = 1'b0; m_irqen = 1'b0;
        bus_read(REG_STATUS, rd);
        checks++; if (rd !== exp_status(1'b0)) begin errors++; $display("FAIL tmo_clear got %h exp %h", rd, exp_status(1'b0)); end

        randomize_operands();
        write_operands();
        launch(OP_UPPER, 1'b0);
        repeat (TMO - 1) @(negedge clk);
        core_model(OP_UPPER, res);
        core_finish(res);
        bus_read(REG_STATUS, rd);
        checks++; if (rd !== exp_status(1'b1)) begin errors++; $display("FAIL tmo_done_wins got %h exp %h", rd, exp_status(1'b1)); end
        bus_read(REG_R_BASE, rd);
        checks++; if (rd !== pack_word(m_r, 0)) begin errors++; $display("FAIL tmo_done_result got %h exp %h", rd, pack_word(m_r, 0)); end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        randomize_operands();
        write_operands();
        launch(OP_LOWER, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (core_go !== 1'b0) begin errors++; $display("FAIL arst_go got %b exp 0", core_go); end
        checks++; if (core_index !== 4'd0 || core_A !== '0) begin errors++; $display("FAIL arst_core got idx=%h A=%h exp 0", core_index, core_A); end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        for (int a = 0; a < NREGS; a++) begin
            bus_read(a, rd);
            checks++; if (rd !== exp_reg(a, 1'b0)) begin errors++; $display("FAIL arst_reg[%0d] got %h exp %h", a, rd, exp_reg(a, 1'b0)); end
        end
    endtask

`ifdef STRING_HW_IRQ_EN
    task automatic test_irq();
        logic [31:0] rd;
        byte unsigned res[STR_BYTES];
        randomize_operands();
        write_operands();
        launch(OP_UPPER, 1'b1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_busy got %b exp 0", irq); end
        core_model(OP_UPPER, res);
        core_finish(res);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq); end
        bus_read(REG_STATUS, rd);
        checks++; if (rd !== exp_status(1'b0)) begin errors++; $display("FAIL irq_status got %h exp %h", rd, exp_status(1'b0)); end
        bus_write(REG_CTRL, 32'h0000_0006);
        m_done = 1'b0; m_to = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_stay_clear got %b exp 0", irq); end
    endtask
`endif

    initial begin
        avs.address    = '0;
        avs.chipselect = 1'b0;
        avs.write      = 1'b0;
        avs.read       = 1'b0;
        avs.writedata  = '0;
        core_done      = 1'b0;
        core_result    = '0;
        model_reset();

        test_reset();
        test_transform(6);
        test_compare();
        test_back_to_back();
        test_busy_writes();
        test_timeout();
`ifdef STRING_HW_IRQ_EN
        test_irq();
`endif
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/string_hw_avalon_ctrl.md
Name: string_hw_avalon_ctrl

Overview:
- Avalon-MM slave front end between the NIOS2 bus and the String_HW core (index 0 compare, 1 to-upper, 2 to-lower).
- Software writes operand strings A and B plus a command word. The block drives the core's go/index/A/B and waits for done.
- On done it captures Result into a readable register and exposes busy/done/timeout status.
- Only path by which software launches the string accelerator.

Parameters:
- MAX_BLOCKS, 2, number of 32-bit words per string; string length = MAX_BLOCKS*4 bytes.
- ADDR_W, 4, word-address width of the slave port; must satisfy 2^ADDR_W >= 2+3*MAX_BLOCKS.
- TIMEOUT_CYCLES, 1024, maximum cycles in BUSY before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  ADDR_W  word address
- chipselect  in  1  slave select
- write  in  1  write strobe (qualified by chipselect)
- writedata  in  32  write data
- read  in  1  read strobe (qualified by chipselect)
- readdata  out  32  registered read data
- core_go  out  1  go to core
- core_index  out  4  operation select to core
- core_A  out  [0:MAX_BLOCKS*4-1][7:0]  operand A
- core_B  out  [0:MAX_BLOCKS*4-1][7:0]  operand B
- core_done  in  1  core completion
- core_result  in  [0:MAX_BLOCKS*4-1][7:0]  core result

Behaviour:
- Reset (async, reset_n=0): readdata=0, core_go=0, core_index=0, A/B/result regs=0, status flags=0, FSM=IDLE, timeout counter=0.
- Register map (word addr):
  - 0 CTRL (W): bit0 START, bit1 CLEAR, bits[7:4] INDEX.
  - 1 STATUS (R): bit0 busy, bit1 done, bit2 timeout, bits[7:4] last INDEX.
  - 2..2+MB-1: A words.
  - 2+MB..2+2MB-1: B words.
  - 2+2MB..2+3MB-1: RESULT words (read-only).
  - Unmapped addresses: read 0, writes ignored.
- Byte packing: word k, byte j maps to string byte 4k+j = writedata[8j+7:8j], so little-endian memory copies land in order. Byte 0 is the MSB of the core's packed vector.
- Reads: readdata updates on the clock edge after chipselect&read; fixed 1-cycle latency, no waitrequest. Holds its value when not reading.
- A, B and INDEX writes are ignored while busy. Writes to STATUS and RESULT are ignored.
- FSM:
  - IDLE: CTRL write with START=1 latches INDEX, clears done/timeout, goes to BUSY. core_go=1 from the next cycle.
  - BUSY: core_go=1, counter increments each cycle.
    - core_done=1: capture core_result the same edge, set done, go to RELEASE.
    - Counter reaches TIMEOUT_CYCLES (nonzero): set timeout, result unchanged, go to RELEASE.
  - RELEASE: core_go=0 for exactly one cycle, then IDLE.
- busy=1 in BUSY and RELEASE.
- START written while busy is ignored. CLEAR=1 in IDLE zeroes done/timeout. START and CLEAR written together act as START.
- core_done and timeout expiring in the same cycle: done wins, timeout stays 0.
- core_done seen outside BUSY is ignored.
- reset_n asserted mid-operation: immediate return to reset values, core_go drops asynchronously.

Optional Feature:
- Macro STRING_HW_IRQ_EN.
- Defined: adds output port irq (1 bit, reset 0) and CTRL bit2 IRQ_ENABLE (stored, reset 0).
  - irq = IRQ_ENABLE & (done | timeout), registered.
  - Cleared by CLEAR or by a new START.
- Undefined: no irq port; CTRL bit2 ignored and reads as 0 in STATUS bit3.

Decomposition:
- Package string_hw_pkg holds:
  - MAX_BLOCKS and string byte count;
  - typedef str_t ([0:MAX_BLOCKS*4-1][7:0]);
  - enum ctrl_state_t {IDLE, BUSY, RELEASE};
  - register offset constants REG_CTRL, REG_STATUS, REG_A_BASE, REG_B_BASE, REG_R_BASE;
  - op codes OP_CMP=0, OP_UPPER=1, OP_LOWER=2.
- One natural sub-module: string_hw_regfile (address decode, byte packing, readdata mux). The FSM and timeout logic stay in the top.

Test Plan:
- Write A words 0x64636261, 0x68676665 ("abcdefgh"), CTRL=0x11 (index 1, START) -> core_go rises next cycle, core_index=1, core_A="abcdefgh". Core model asserts done with "ABCDEFGH" -> RESULT word0 reads 0x44434241, STATUS=0x12, core_go low for exactly one cycle.
- Compare "ab"/"ab" (index 0) with core result 1 -> RESULT last word reads 0x01000000, done=1. A repeated START after RELEASE relaunches cleanly.
- Write A=0xFFFFFFFF while busy -> core_A is unchanged. START while busy -> ignored, no extra go cycle.
- Core never asserts done, TIMEOUT_CYCLES=16 -> after 16 BUSY cycles STATUS=0x05 (timeout, not done), RESULT unchanged. CLEAR -> STATUS=0x00 in IDLE.
- Assert reset_n=0 mid-BUSY -> core_go=0 immediately, all registers read 0 after release.
- With STRING_HW_IRQ_EN defined, CTRL=0x15 and the core completes -> irq=1 one cycle after done. CLEAR -> irq=0.
